// File: rtl/mem_ctrl.sv
// Arbitrating controller between one write producer, one read consumer and a FIFO-style memory.
// Optional define MEM_CTRL_ROUND_ROBIN_EN alternates tie grants; otherwise writes win every tie.
module mem_ctrl #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 136
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       mem_wen,
  output logic                       mem_ren,
  output logic [WIDTH-1:0]           mem_wdata,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDWAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ready_q, wr_ready_d;
  logic             mem_wen_q, mem_wen_d;
  logic             mem_ren_q, mem_ren_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             wr_elig, rd_elig, grant_wr, grant_rd;

`ifdef MEM_CTRL_ROUND_ROBIN_EN
  typedef enum logic {GRANT_WR, GRANT_RD} grant_t;
  grant_t last_grant_q, last_grant_d;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    wr_elig = wr_valid & ~full;
    rd_elig = rd_req & ~empty;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    grant_wr = wr_elig & (~rd_elig | (last_grant_q == GRANT_RD));
`else
    grant_wr = wr_elig;
`endif
    grant_rd = rd_elig & ~grant_wr;
  end

  // Strobes are registered at the grant so they line up with the WRITE/READ state itself.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ready_d  = 1'b0;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d     = WRITE;
          wr_ready_d  = 1'b1;
          mem_wen_d   = 1'b1;
          mem_wdata_d = wr_data;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
          last_grant_d = GRANT_WR;
`endif
        end else if (grant_rd) begin
          state_d   = READ;
          mem_ren_d = 1'b1;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
          last_grant_d = GRANT_RD;
`endif
        end
      end
      WRITE: begin
        count_d = count_q + CW'(1);
        state_d = IDLE;
      end
      READ: begin
        count_d = count_q - CW'(1);
        state_d = RDWAIT;
      end
      RDWAIT: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      last_grant_q <= GRANT_RD;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Memory-facing strobes are forced quiet for the whole time reset is high.
  assign wr_ready  = wr_ready_q & ~reset;
  assign mem_wen   = mem_wen_q & ~reset;
  assign mem_ren   = mem_ren_q & ~reset;
  assign mem_wdata = reset ? '0 : mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 64: number of memory entries managed.
REQ-002 SHALL provide parameter WIDTH, default 136: data word width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_valid, input, 1: producer holds a word to store.
REQ-006 SHALL have port wr_data, input, WIDTH: producer word; held stable while wr_valid=1 and wr_ready=0.
REQ-007 SHALL have port wr_ready, output, 1: write accepted this cycle.
REQ-008 SHALL have port rd_req, input, 1: consumer requests one word (level).
REQ-009 SHALL have port rd_valid, output, 1: rd_data valid (1-cycle pulse).
REQ-010 SHALL have port rd_data, output, WIDTH: last word read.
REQ-011 SHALL have port mem_wen, output, 1: write strobe to memory.
REQ-012 SHALL have port mem_ren, output, 1: read-advance strobe to memory.
REQ-013 SHALL have port mem_wdata, output, WIDTH: data to memory.
REQ-014 SHALL have port mem_rdata, input, WIDTH: registered read data from memory.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1: stored-word count.
REQ-016 SHALL have ports full and empty, outputs, 1 each: count==DEPTH and count==0.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, RDWAIT.
REQ-018 In IDLE: wr_elig = wr_valid & !full; rd_elig = rd_req & !empty; only wr_elig -> WRITE; only rd_elig -> READ; neither -> IDLE.
REQ-019 In IDLE with both eligible: grant the side not granted last (last_grant register, updated on every grant).
REQ-020 WRITE lasts 1 cycle: wr_ready=1, mem_wen=1, mem_wdata=wr_data, count+1; next IDLE.
REQ-021 READ lasts 1 cycle: mem_ren=1, count-1; next RDWAIT.
REQ-022 RDWAIT lasts 1 cycle: rd_data <= mem_rdata at cycle end, rd_valid=1 in the following cycle only; next IDLE.
REQ-023 Read latency SHALL be exactly 3 cycles from IDLE grant cycle to rd_valid pulse.
REQ-024 wr_ready, mem_wen, mem_ren SHALL be 0 in all states other than those stated; never both strobes in one cycle.
REQ-025 full SHALL block write grant; empty SHALL block read grant; count SHALL never exceed DEPTH nor go below 0.
REQ-026 rd_data SHALL hold its value until the next RDWAIT completion.
REQ-027 Requests deasserted after the IDLE grant SHALL NOT abort the granted WRITE/READ sequence.

Reset
REQ-028 reset=1 SHALL, at the next clk edge, force state IDLE, count=0, last_grant=READ (so writes win the first tie), rd_valid=0, rd_data=0.
REQ-029 While reset=1, wr_ready, mem_wen, mem_ren SHALL be 0; mem_wdata SHALL be 0.
REQ-030 Reset asserted mid-sequence (WRITE/READ/RDWAIT) SHALL abandon it with no rd_valid pulse and no count update.
REQ-031 Memory pointers SHALL be reset by the same system reset as this block (memory's own reset port, driven by the system reset).

Configuration
REQ-032 Macro MEM_CTRL_ROUND_ROBIN_EN defined: tie arbitration per REQ-019.
REQ-033 Macro MEM_CTRL_ROUND_ROBIN_EN undefined: fixed priority, write always wins ties; last_grant unused.

Verification
REQ-034 Reset, then wr_valid=1 with data 0xA5..A5 for 1 word -> wr_ready pulse on cycle 2, mem_wen=1 same cycle, count 0->1, empty 1->0.
REQ-035 Write 64 words, hold wr_valid=1 -> full=1, count=64, no further wr_ready/mem_wen.
REQ-036 count=0, rd_req=1 -> no mem_ren, rd_valid stays 0 for 10 cycles.
REQ-037 count=3, wr_valid=1 and rd_req=1 continuously, MEM_CTRL_ROUND_ROBIN_EN defined -> grants W,R,W,R alternate; count oscillates 4,3,4,3; undefined -> writes only until full.
REQ-038 Read granted at cycle N with mem_rdata=0x1234 in RDWAIT -> mem_ren at N+1, rd_valid=1 and rd_data=0x1234 at N+3.
REQ-039 reset asserted in RDWAIT with count=5 -> next cycle IDLE, count=0, rd_valid=0.
